// File: rtl/traffic_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_ctrl_if
//  Description : Signal bundle for the N-phase intersection controller.
//                Carries the control inputs (mode, left_en, hold, emerg) and
//                the registered light/status outputs.
//                master modport : the side that drives the controls
//                slave  modport : the controller itself
//  Ports       : mode[1:0], left_en[NUM_PHASES], hold, emerg      (to slave)
//                phase_idx[PW], sub_state[3], cnt[TW],
//                left_green/green/yellow/red[NUM_PHASES],
//                emerg_active                                      (from slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface traffic_phase_ctrl_if #(
   parameter int NUM_PHASES = 4,
   parameter int TW         = 8
);
   localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

   logic [1:0]            mode;
   logic [NUM_PHASES-1:0] left_en;
   logic                  hold;
   logic                  emerg;

   logic [PW-1:0]         phase_idx;
   logic [2:0]            sub_state;
   logic [TW-1:0]         cnt;
   logic [NUM_PHASES-1:0] left_green;
   logic [NUM_PHASES-1:0] green;
   logic [NUM_PHASES-1:0] yellow;
   logic [NUM_PHASES-1:0] red;
   logic                  emerg_active;

   modport master (
      output mode, left_en, hold, emerg,
      input  phase_idx, sub_state, cnt, left_green, green, yellow, red,
             emerg_active
   );

   modport slave (
      input  mode, left_en, hold, emerg,
      output phase_idx, sub_state, cnt, left_green, green, yellow, red,
             emerg_active
   );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_ctrl
//  Description : Round-robin N-phase signal controller. Each phase runs
//                LEFT (optional, per left_en) -> GO -> YELLOW -> ALLRED with
//                durations from a mode-selected table latched at phase start.
//                hold freezes state and timer; emerg forces a safe path to
//                all-red (PREEMPT) and overrides hold.
//  Ports       : clk   - clock
//                rst_n - synchronous active-low reset
//                bus   - traffic_phase_ctrl_if.slave (controls in, lights out)
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl #(
   parameter int NUM_PHASES = 4,
   parameter int TW         = 8,
   parameter int T_LEFT_M0  = 15,
   parameter int T_GO_M0    = 25,
   parameter int T_LEFT_M1  = 25,
   parameter int T_GO_M1    = 45,
   parameter int T_LEFT_M2  = 35,
   parameter int T_GO_M2    = 60,
   parameter int T_YELLOW   = 5,
   parameter int T_ALLRED   = 2
) (
   input wire                   clk,
   input wire                   rst_n,
   traffic_phase_ctrl_if.slave  bus
);

   localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

   // Durations zero-extended to the timer width.
   localparam logic [TW-1:0] c_t_left_m0 = TW'(T_LEFT_M0);
   localparam logic [TW-1:0] c_t_go_m0   = TW'(T_GO_M0);
   localparam logic [TW-1:0] c_t_left_m1 = TW'(T_LEFT_M1);
   localparam logic [TW-1:0] c_t_go_m1   = TW'(T_GO_M1);
   localparam logic [TW-1:0] c_t_left_m2 = TW'(T_LEFT_M2);
   localparam logic [TW-1:0] c_t_go_m2   = TW'(T_GO_M2);
   localparam logic [TW-1:0] c_t_yellow  = TW'(T_YELLOW);
   localparam logic [TW-1:0] c_t_allred  = TW'(T_ALLRED);
   localparam logic [TW-1:0] c_cnt_one   = TW'(1);

   localparam logic [PW-1:0]         c_last_phase = PW'(NUM_PHASES - 1);
   localparam logic [PW-1:0]         c_phase_one  = PW'(1);
   localparam logic [NUM_PHASES-1:0] c_phase_bit0 = NUM_PHASES'(1);

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_LEFT    = 3'd1,
      ST_GO      = 3'd2,
      ST_YELLOW  = 3'd3,
      ST_ALLRED  = 3'd4,
      ST_PREEMPT = 3'd5
   } state_e;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   state_e                state_q,        state_d;
   logic [PW-1:0]         phase_q,        phase_d;
   logic [TW-1:0]         cnt_q,          cnt_d;
   logic [1:0]            mode_q,         mode_d;
   logic                  emerg_active_q, emerg_active_d;
   logic [NUM_PHASES-1:0] left_green_q,   left_green_d;
   logic [NUM_PHASES-1:0] green_q,        green_d;
   logic [NUM_PHASES-1:0] yellow_q,       yellow_d;
   logic [NUM_PHASES-1:0] red_q,          red_d;

   // -------------------------------------------------------------------------
   // Helpers
   // -------------------------------------------------------------------------
   function automatic logic [TW-1:0] f_left_dur(input logic [1:0] m);
      case (m)
         2'd1:    f_left_dur = c_t_left_m1;
         2'd2:    f_left_dur = c_t_left_m2;
         default: f_left_dur = c_t_left_m0;
      endcase
   endfunction

   function automatic logic [TW-1:0] f_go_dur(input logic [1:0] m);
      case (m)
         2'd1:    f_go_dur = c_t_go_m1;
         2'd2:    f_go_dur = c_t_go_m2;
         default: f_go_dur = c_t_go_m0;
      endcase
   endfunction

   logic [1:0]            w_mode_in;
   logic [PW-1:0]         w_next_phase;
   logic [PW-1:0]         w_start_phase;
   logic                  w_start_left;
   logic                  w_freeze;
   logic                  w_last;
   logic                  w_begin_phase;
   logic [NUM_PHASES-1:0] w_phase_bit;

   // Mode 3 is folded into mode 0 before it is ever stored.
   assign w_mode_in    = (bus.mode == 2'd3) ? 2'd0 : bus.mode;
   // Explicit wrap so non-power-of-two phase counts work.
   assign w_next_phase = (phase_q == c_last_phase) ? '0 : (phase_q + c_phase_one);
   // INIT starts the current phase (0); ALLRED expiry starts the next one.
   assign w_start_phase = (state_q == ST_INIT) ? phase_q : w_next_phase;
   assign w_start_left  = bus.left_en[w_start_phase];
   // emerg always overrides hold.
   assign w_freeze = bus.hold & ~bus.emerg;
   // Treating 0 like 1 guarantees the timer can never wrap below zero.
   assign w_last   = (cnt_q <= c_cnt_one);

   // -------------------------------------------------------------------------
   // Next-state / next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      cnt_d          = cnt_q;
      mode_d         = mode_q;
      emerg_active_d = emerg_active_q;
      w_begin_phase  = 1'b0;

      case (state_q)
         ST_INIT: begin
            // emerg is not examined here; the first LEFT/GO cycle reacts.
            w_begin_phase = 1'b1;
         end

         ST_LEFT, ST_GO: begin
            if (bus.emerg) begin
               state_d        = ST_YELLOW;
               cnt_d          = c_t_yellow;
               emerg_active_d = 1'b1;
            end else if (!bus.hold) begin
               if (!w_last) begin
                  cnt_d = cnt_q - c_cnt_one;
               end else if (state_q == ST_LEFT) begin
                  // GO keeps using the mode latched at phase start.
                  state_d = ST_GO;
                  cnt_d   = f_go_dur(mode_q);
               end else begin
                  state_d = ST_YELLOW;
                  cnt_d   = c_t_yellow;
               end
            end
         end

         ST_YELLOW: begin
            if (!w_freeze) begin
               if (!w_last) begin
                  cnt_d = cnt_q - c_cnt_one;
               end else begin
                  state_d = ST_ALLRED;
                  cnt_d   = c_t_allred;
               end
            end
         end

         ST_ALLRED: begin
            if (!w_freeze) begin
               if (!w_last) begin
                  cnt_d = cnt_q - c_cnt_one;
               end else if (bus.emerg) begin
                  state_d        = ST_PREEMPT;
                  cnt_d          = '0;
                  emerg_active_d = 1'b1;
               end else begin
                  w_begin_phase = 1'b1;
               end
            end
         end

         ST_PREEMPT: begin
            // Held purely by emerg; hold has no effect here.
            cnt_d = '0;
            if (!bus.emerg) begin
               state_d = ST_ALLRED;
               cnt_d   = c_t_allred;
            end
         end

         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase

      // Phase start: latch mode, sample left_en, choose first sub-state.
      if (w_begin_phase) begin
         phase_d        = w_start_phase;
         mode_d         = w_mode_in;
         emerg_active_d = 1'b0;
         if (w_start_left) begin
            state_d = ST_LEFT;
            cnt_d   = f_left_dur(w_mode_in);
         end else begin
            state_d = ST_GO;
            cnt_d   = f_go_dur(w_mode_in);
         end
      end

      // Lights are decoded from the next state so they come straight from flops.
      w_phase_bit  = c_phase_bit0 << phase_d;
      left_green_d = (state_d == ST_LEFT)   ? w_phase_bit : '0;
      green_d      = (state_d == ST_GO)     ? w_phase_bit : '0;
      yellow_d     = (state_d == ST_YELLOW) ? w_phase_bit : '0;
      red_d        = ~(left_green_d | green_d | yellow_d);
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_INIT;
         phase_q        <= '0;
         cnt_q          <= '0;
         mode_q         <= 2'd0;
         emerg_active_q <= 1'b0;
         left_green_q   <= '0;
         green_q        <= '0;
         yellow_q       <= '0;
         red_q          <= '1;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         cnt_q          <= cnt_d;
         mode_q         <= mode_d;
         emerg_active_q <= emerg_active_d;
         left_green_q   <= left_green_d;
         green_q        <= green_d;
         yellow_q       <= yellow_d;
         red_q          <= red_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.phase_idx    = phase_q;
   assign bus.sub_state    = state_q;
   assign bus.cnt          = cnt_q;
   assign bus.left_green   = left_green_q;
   assign bus.green        = green_q;
   assign bus.yellow       = yellow_q;
   assign bus.red          = red_q;
   assign bus.emerg_active = emerg_active_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_phase_ctrl
//  Description : Scoreboard testbench for traffic_phase_ctrl. Stimulus pushes
//                the predicted post-edge outputs of a behavioural model into a
//                queue; an independent monitor pops and compares each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

   localparam int NP = 4;
   localparam int TW = 8;
   localparam int T_Y = 5;
   localparam int T_A = 2;

   // Duration tables indexed by raw mode; index 3 repeats mode 0.
   int dur_left [4] = '{15, 25, 35, 15};
   int dur_go   [4] = '{25, 45, 60, 25};

   logic clk;
   logic rst_n;

   traffic_phase_ctrl_if #(.NUM_PHASES(NP), .TW(TW)) bus ();

   traffic_phase_ctrl #(.NUM_PHASES(NP), .TW(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------
   typedef struct {
      int            st;
      int            ph;
      int            cnt;
      logic [NP-1:0] lg;
      logic [NP-1:0] g;
      logic [NP-1:0] y;
      logic [NP-1:0] r;
      bit            ea;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: sub-state numbers follow the published encoding
   // ---------------------------------------------------------------------
   int m_st, m_ph, m_cnt, m_mode;
   bit m_ea;

   task automatic start_phase(input int p, input int md, input logic [NP-1:0] le);
      m_ph   = p;
      m_mode = md;
      m_ea   = 1'b0;
      if (le[p]) begin m_st = 1; m_cnt = dur_left[md]; end
      else       begin m_st = 2; m_cnt = dur_go[md];   end
   endtask

   task automatic model_step(input bit rn, input int md, input logic [NP-1:0] le,
                             input bit hd, input bit em);
      bit stall;
      stall = hd && !em;
      if (!rn) begin
         m_st = 0; m_ph = 0; m_cnt = 0; m_mode = 0; m_ea = 1'b0;
         return;
      end
      case (m_st)
         0: start_phase(0, md, le);
         1, 2: begin
            if (em) begin
               m_st = 3; m_cnt = T_Y; m_ea = 1'b1;
            end else if (!hd) begin
               if (m_cnt > 1)      m_cnt--;
               else if (m_st == 1) begin m_st = 2; m_cnt = dur_go[m_mode]; end
               else                begin m_st = 3; m_cnt = T_Y; end
            end
         end
         3: if (!stall) begin
               if (m_cnt > 1) m_cnt--;
               else begin m_st = 4; m_cnt = T_A; end
            end
         4: if (!stall) begin
               if (m_cnt > 1) m_cnt--;
               else if (em)   begin m_st = 5; m_cnt = 0; m_ea = 1'b1; end
               else           start_phase((m_ph + 1) % NP, md, le);
            end
         default: if (!em) begin m_st = 4; m_cnt = T_A; end
      endcase
   endtask

   function automatic exp_t snapshot();
      exp_t          e;
      logic [NP-1:0] bitv;
      bitv  = NP'(1) << m_ph;
      e.st  = m_st;
      e.ph  = m_ph;
      e.cnt = m_cnt;
      e.ea  = m_ea;
      e.lg  = (m_st == 1) ? bitv : '0;
      e.g   = (m_st == 2) ? bitv : '0;
      e.y   = (m_st == 3) ? bitv : '0;
      e.r   = ~(e.lg | e.g | e.y);
      return e;
   endfunction

   // One clock of stimulus: drive, predict, enqueue, advance.
   task automatic cycle(input bit rn, input int md, input logic [NP-1:0] le,
                        input bit hd, input bit em);
      rst_n       = rn;
      bus.mode    = md[1:0];
      bus.left_en = le;
      bus.hold    = hd;
      bus.emerg   = em;
      model_step(rn, md, le, hd, em);
      sb.push_back(snapshot());
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cyc++;
            chk("sub_state",    bus.sub_state,    e.st);
            chk("phase_idx",    bus.phase_idx,    e.ph);
            chk("cnt",          bus.cnt,          e.cnt);
            chk("left_green",   bus.left_green,   e.lg);
            chk("green",        bus.green,        e.g);
            chk("yellow",       bus.yellow,       e.y);
            chk("red",          bus.red,          e.r);
            chk("emerg_active", bus.emerg_active, e.ea);
            chk("lights_lit",   $countones(bus.left_green | bus.green | bus.yellow),
                $countones(e.lg | e.g | e.y));
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int            md;
      logic [NP-1:0] le;
      int            em_left;
      int            hd_left;
      bit            rn;

      rst_n = 1'b0;
      bus.mode = 2'd0; bus.left_en = '1; bus.hold = 1'b0; bus.emerg = 1'b0;

      // Reset, then a full default cycle through all four phases plus wrap.
      repeat (3)   cycle(1'b0, 0, 4'b1111, 1'b0, 1'b0);
      repeat (200) cycle(1'b1, 0, 4'b1111, 1'b0, 1'b0);

      // Left turns only on phases 0 and 2.
      cycle(1'b0, 0, 4'b0101, 1'b0, 1'b0);
      repeat (140) cycle(1'b1, 0, 4'b0101, 1'b0, 1'b0);

      // Mode change to 2 during phase 0 GO, held for two phases.
      cycle(1'b0, 0, 4'b1111, 1'b0, 1'b0);
      repeat (20)  cycle(1'b1, 0, 4'b1111, 1'b0, 1'b0);
      repeat (160) cycle(1'b1, 2, 4'b1111, 1'b0, 1'b0);

      // Hold for 10 cycles in GO, then a 20-cycle emergency in GO.
      cycle(1'b0, 0, 4'b1111, 1'b0, 1'b0);
      repeat (20)  cycle(1'b1, 0, 4'b1111, 1'b0, 1'b0);
      repeat (10)  cycle(1'b1, 0, 4'b1111, 1'b1, 1'b0);
      repeat (50)  cycle(1'b1, 0, 4'b1111, 1'b0, 1'b0);
      repeat (20)  cycle(1'b1, 0, 4'b1111, 1'b0, 1'b1);
      repeat (60)  cycle(1'b1, 0, 4'b1111, 1'b0, 1'b0);

      // Randomised traffic: mode/left_en drift, hold and emerg bursts,
      // occasional reset, including reset landing mid-YELLOW.
      md = 0; le = 4'b1111; em_left = 0; hd_left = 0;
      for (int i = 0; i < 3500; i++) begin
         if ($urandom_range(0, 59) == 0)  md = $urandom_range(0, 3);
         if ($urandom_range(0, 149) == 0) le = NP'($urandom);
         if (em_left == 0 && $urandom_range(0, 249) == 0) em_left = $urandom_range(1, 40);
         if (hd_left == 0 && $urandom_range(0, 79) == 0)  hd_left = $urandom_range(1, 15);
         rn = !($urandom_range(0, 699) == 0);
         if (bus.sub_state == 3'd3 && $urandom_range(0, 49) == 0) rn = 1'b0;
         cycle(rn, md, le, hd_left > 0, em_left > 0);
         if (em_left > 0) em_left--;
         if (hd_left > 0) hd_left--;
      end

      bus.hold = 1'b0; bus.emerg = 1'b0;
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      #1;
      chk("scoreboard_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
